tdm_demux_1to4: RTL and testbench

Registered 1-to-4 time-division demultiplexer. It takes a single word stream, one word per valid cycle, where a sync flag marks channel-0 words. Each word is routed into one of four held channel registers (A/B/C/D), in the same channel order as the team's 4:1 mux (Sel 00=A, 01=B, 10=C, 11=D). It sits at the receive end of a TDM link, after the serialising mux, and restores the four parallel channels with per-channel update strobes and frame alignment tracking.

---
 rtl/tdm_demux_1to4.sv | 111 +++++++++++
 tb/tb_tdm_demux_1to4.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/tdm_demux_1to4.sv
// Registered 1-to-4 TDM demultiplexer with sync-based frame alignment.
// Restores four held channel registers plus per-channel update strobes.
module tdm_demux_1to4 #(
    parameter int bit_width = 1
) (
    input  logic                 i_Clk,
    input  logic                 i_Rst,
    input  logic [bit_width-1:0] i_Data,
    input  logic                 i_Valid,
    input  logic                 i_Sync,
    output logic [bit_width-1:0] o_A,
    output logic [bit_width-1:0] o_B,
    output logic [bit_width-1:0] o_C,
    output logic [bit_width-1:0] o_D,
    output logic [3:0]           o_Strobe,
    output logic                 o_Frame,
    output logic                 o_Locked,
    output logic                 o_Sync_Err,
    output logic [1:0]           o_Chan
);

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic [1:0] chan_nxt;
    logic [3:0] strobe_nxt;
    logic       frame_nxt;
    logic       err_nxt;

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            state <= HUNT;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (i_Valid && i_Sync) begin
            state_nxt = LOCKED;
        end
    end

    always_comb begin
        chan_nxt   = o_Chan;
        strobe_nxt = 4'b0000;
        frame_nxt  = 1'b0;
        err_nxt    = 1'b0;
        if (i_Valid) begin
            unique case (state)
                HUNT: begin
                    if (i_Sync) begin
                        strobe_nxt = 4'b0001;
                        chan_nxt   = 2'd1;
                    end
                end
                LOCKED: begin
                    if (i_Sync) begin
                        // a sync always realigns to channel A
                        strobe_nxt = 4'b0001;
                        chan_nxt   = 2'd1;
                        err_nxt    = (o_Chan != 2'd0);
                    end else begin
                        strobe_nxt = 4'b0001 << o_Chan;
                        chan_nxt   = o_Chan + 2'd1;
                        frame_nxt  = (o_Chan == 2'd3);
                    end
                end
                default: begin
                    strobe_nxt = 4'b0000;
                end
            endcase
        end
    end

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            o_Chan     <= 2'd0;
            o_Strobe   <= 4'b0000;
            o_Frame    <= 1'b0;
            o_Sync_Err <= 1'b0;
        end else begin
            o_Chan     <= chan_nxt;
            o_Strobe   <= strobe_nxt;
            o_Frame    <= frame_nxt;
            o_Sync_Err <= err_nxt;
        end
    end

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            o_A <= '0;
            o_B <= '0;
            o_C <= '0;
            o_D <= '0;
        end else begin
            if (strobe_nxt[0]) o_A <= i_Data;
            if (strobe_nxt[1]) o_B <= i_Data;
            if (strobe_nxt[2]) o_C <= i_Data;
            if (strobe_nxt[3]) o_D <= i_Data;
        end
    end

    assign o_Locked = (state == LOCKED);

endmodule

// File: tb/tb_tdm_demux_1to4.sv
// Scoreboard bench for tdm_demux_1to4: directed cases then random traffic
// against a channel-array reference model.
module tb_tdm_demux_1to4;

    localparam int W = 8;

    logic         clk;
    logic         rst;
    logic [W-1:0] data;
    logic         valid;
    logic         sync;
    logic [W-1:0] a, b, c, d;
    logic [3:0]   strobe;
    logic         frame;
    logic         locked;
    logic         sync_err;
    logic [1:0]   chan;

    tdm_demux_1to4 #(.bit_width(W)) dut (
        .i_Clk      (clk),
        .i_Rst      (rst),
        .i_Data     (data),
        .i_Valid    (valid),
        .i_Sync     (sync),
        .o_A        (a),
        .o_B        (b),
        .o_C        (c),
        .o_D        (d),
        .o_Strobe   (strobe),
        .o_Frame    (frame),
        .o_Locked   (locked),
        .o_Sync_Err (sync_err),
        .o_Chan     (chan)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef logic [40:0] snap_t;

    snap_t        sb[$];
    int           total = 0;
    int           bad = 0;
    int           frames_seen = 0;
    int           errs_seen = 0;
    logic [W-1:0] m_ch[4];
    int           m_chan;
    bit           m_locked;

    function automatic snap_t pack(input logic [W-1:0] pa, pb, pc, pd,
                                   input logic [3:0] ps, input logic pf,
                                   input logic pe, input logic pl,
                                   input logic [1:0] pc2);
        return {pa, pb, pc, pd, ps, pf, pe, pl, pc2};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_ch[i] = '0;
        m_chan   = 0;
        m_locked = 0;
    endtask

    // issue one cycle of stimulus; expected post-edge state goes to scoreboard
    task automatic step(input bit v, input bit s, input logic [W-1:0] dv);
        logic [3:0] es;
        logic       ef;
        logic       ee;
        es = 4'b0;
        ef = 1'b0;
        ee = 1'b0;
        if (v) begin
            if (s) begin
                ee = m_locked && (m_chan != 0);
                m_ch[0]  = dv;
                es       = 4'b0001;
                m_chan   = 1;
                m_locked = 1;
            end else if (m_locked) begin
                m_ch[m_chan] = dv;
                es[m_chan]   = 1'b1;
                ef           = (m_chan == 3);
                m_chan       = (m_chan + 1) % 4;
            end
        end
        valid = v;
        sync  = s;
        data  = dv;
        sb.push_back(pack(m_ch[0], m_ch[1], m_ch[2], m_ch[3], es, ef, ee,
                          m_locked, 2'(m_chan)));
        @(posedge clk);
        #2;
    endtask

    initial begin : monitor
        snap_t got;
        snap_t exp;
        forever begin
            @(posedge clk);
            #1;
            if (frame) frames_seen++;
            if (sync_err) errs_seen++;
            if (sb.size() > 0) begin
                exp = sb.pop_front();
                got = pack(a, b, c, d, strobe, frame, sync_err, locked, chan);
                total++;
                if (got !== exp) begin
                    bad++;
                    $display("FAIL cycle_check t=%0t got=%h want=%h", $time, got, exp);
                end
            end
        end
    end

    task automatic check(input string name, input logic [63:0] got,
                         input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    initial begin
        int waited;
        rst   = 1'b1;
        valid = 1'b0;
        sync  = 1'b0;
        data  = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #2;
        check("reset_state", 64'(pack(a, b, c, d, strobe, frame, sync_err, locked, chan)), 64'd0);
        rst = 1'b0;

        // hunting: words without sync dropped
        step(1, 0, 8'h05);
        step(1, 0, 8'h06);
        step(1, 0, 8'h07);
        step(1, 0, 8'h08);
        check("hunt_unlocked", 64'(locked), 64'd0);

        // first frame
        step(1, 1, 8'h11);
        step(1, 0, 8'h22);
        step(1, 0, 8'h33);
        step(1, 0, 8'h44);
        check("frame1_d", 64'(d), 64'h44);

        // misaligned sync at chan 2
        step(1, 0, 8'h66);
        step(1, 0, 8'h77);
        step(1, 1, 8'h55);
        check("realign_c_held", 64'(c), 64'h33);

        // gaps with sync high
        step(1, 1, 8'hA0);
        step(0, 1, 8'hFF);
        step(1, 0, 8'hA1);
        step(0, 1, 8'hFE);
        step(1, 0, 8'hA2);
        step(0, 1, 8'hFD);
        step(1, 0, 8'hA3);
        check("gap_final_d", 64'(d), 64'hA3);

        // async reset mid-frame
        step(1, 1, 8'h31);
        step(1, 0, 8'h32);
        check("pre_reset_chan", 64'(chan), 64'd2);
        valid = 1'b0;
        #3;
        rst = 1'b1;
        #1;
        check("async_reset", 64'(pack(a, b, c, d, strobe, frame, sync_err, locked, chan)), 64'd0);
        model_reset();
        @(posedge clk);
        #2;
        rst = 1'b0;
        step(1, 0, 8'h41);
        step(1, 0, 8'h42);

        // two back-to-back frames
        frames_seen = 0;
        errs_seen   = 0;
        for (int f = 0; f < 2; f++)
            for (int k = 0; k < 4; k++)
                step(1, k == 0, 8'(8'h80 + f * 4 + k));
        check("two_frames", 64'(frames_seen), 64'd2);
        check("two_frames_err", 64'(errs_seen), 64'd0);

        // random traffic
        for (int i = 0; i < 400; i++)
            step($urandom_range(0, 3) != 0, $urandom_range(0, 5) == 0,
                 8'($urandom));

        valid = 1'b0;
        waited = 0;
        while (sb.size() > 0 && waited < 20) begin
            @(posedge clk);
            waited++;
        end
        #2;
        check("drain", 64'(sb.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
